// File: rtl/miner_pkg.sv
// Shared widths, data1 field layout and scan FSM state type for the mining datapath.
package miner_pkg;

  localparam int NONCE_W   = 32;
  localparam int HASH_W    = 256;
  localparam int TAIL_W    = 96;
  localparam int DATA1_W   = 512;
  localparam int NONCE_LSB = 96;
  localparam int PAD_W     = DATA1_W - NONCE_LSB - NONCE_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

endpackage

// File: rtl/nonce_inflight_tracker.sv
// Tracks which hasher pipeline slots hold real work and which nonce the
// current hash2 output belongs to.
module nonce_inflight_tracker
  import miner_pkg::*;
#(
  parameter int DEPTH = 130
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [NONCE_W-1:0] load_nonce,
  input  logic               push,
  output logic               valid_out,
  output logic [NONCE_W-1:0] ret_nonce,
  output logic               empty
);

  logic [DEPTH-1:0] valid_sr;

  always_ff @(posedge clk) begin
    if (reset || clear) valid_sr <= '0;
    else                valid_sr <= {valid_sr[DEPTH-2:0], push};
  end

  // Results return strictly in issue order, so a counter realigns them.
  always_ff @(posedge clk) begin
    if (reset)          ret_nonce <= '0;
    else if (load)      ret_nonce <= load_nonce;
    else if (valid_out) ret_nonce <= ret_nonce + 1'b1;
  end

  assign valid_out = valid_sr[DEPTH-1];
  assign empty     = (valid_sr == '0);

endmodule

// File: rtl/nonce_scanner.sv
// Issues one nonce per cycle into sha256_double and checks returning hashes against the target.
// Optional hit counter output enabled by NONCE_SCANNER_HIT_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for a job, work_ready high
// SCAN  | issuing nonces start..end, one per cycle
// DRAIN | issue finished, waiting for in-flight results to return
module nonce_scanner
  import miner_pkg::*;
#(
  parameter int HASH_LATENCY = 130
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [HASH_W-1:0]  work_midstate,
  input  logic [TAIL_W-1:0]  work_tail,
  input  logic [HASH_W-1:0]  work_target,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               abort,
  output logic [HASH_W-1:0]  hash0,
  output logic [DATA1_W-1:0] data1,
  input  logic [HASH_W-1:0]  hash2,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               found_overflow,
  output logic               busy,
  output logic               done
`ifdef NONCE_SCANNER_HIT_COUNT_EN
  ,
  output logic [NONCE_W-1:0] hit_count
`endif
);

  scan_state_t        state;
  logic [HASH_W-1:0]  midstate_q;
  logic [HASH_W-1:0]  target_q;
  logic [TAIL_W-1:0]  tail_q;
  logic [NONCE_W-1:0] issue_nonce;
  logic [NONCE_W-1:0] end_q;
  logic [NONCE_W-1:0] ret_nonce;
  logic               valid_out;
  logic               trk_empty;
  logic               accept;
  logic               discard;
  logic               hit;
  logic               take;

  // abort outranks accept in IDLE and kills in-flight results elsewhere
  assign accept  = (state == IDLE) && work_valid && work_ready && !abort;
  assign discard = abort && (state != IDLE);
  assign hit     = valid_out && !discard && (hash2 <= target_q);
  assign take    = found_valid && found_ready;

  assign hash0 = midstate_q;
  assign data1 = {{PAD_W{1'b0}}, issue_nonce, tail_q};

  nonce_inflight_tracker #(
    .DEPTH(HASH_LATENCY)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (discard),
    .load       (accept),
    .load_nonce (nonce_start),
    .push       ((state == SCAN) && !abort),
    .valid_out  (valid_out),
    .ret_nonce  (ret_nonce),
    .empty      (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      work_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      midstate_q  <= '0;
      target_q    <= '0;
      tail_q      <= '0;
      issue_nonce <= '0;
      end_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            midstate_q  <= work_midstate;
            target_q    <= work_target;
            tail_q      <= work_tail;
            issue_nonce <= nonce_start;
            end_q       <= nonce_end;
            work_ready  <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end else begin
            work_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            work_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            issue_nonce <= issue_nonce + 1'b1;
            if (issue_nonce == end_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort || trk_empty) begin
            done       <= !abort;
            work_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      found_valid    <= 1'b0;
      found_nonce    <= '0;
      found_overflow <= 1'b0;
    end else if (hit) begin
      if (!found_valid || found_ready) begin
        found_valid <= 1'b1;
        found_nonce <= ret_nonce;
      end else begin
        found_overflow <= 1'b1;
      end
    end else if (take) begin
      found_valid <= 1'b0;
    end
  end

`ifdef NONCE_SCANNER_HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept)                   hit_count <= '0;
    else if (hit && (hit_count != '1))     hit_count <= hit_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner with a 4-deep hasher model and a found-nonce scoreboard.
module tb_nonce_scanner;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_tail;
  logic [255:0] work_target;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         abort;
  logic [255:0] hash0;
  logic [511:0] data1;
  logic [255:0] hash2;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;
  logic         found_overflow;
  logic         busy;
  logic         done;
`ifdef NONCE_SCANNER_HIT_COUNT_EN
  logic [31:0]  hit_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc;
  int done0;
  logic [31:0] sb[$];
  logic [31:0] pipe[LAT];

  nonce_scanner #(.HASH_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_tail(work_tail), .work_target(work_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .hash0(hash0), .data1(data1), .hash2(hash2),
    .found_valid(found_valid), .found_ready(found_ready), .found_nonce(found_nonce),
    .found_overflow(found_overflow), .busy(busy), .done(done)
`ifdef NONCE_SCANNER_HIT_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  // hasher model: LAT register stages; only nonce 0x1234 hashes to zero
  always @(posedge clk) begin
    pipe[0] <= data1[127:96];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign hash2 = (pipe[LAT-1] == 32'h0000_1234) ? '0 : '1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && found_valid === 1'b1 && found_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL found_unexpected: got %0h expected no result", found_nonce);
      end else begin
        check("found_nonce", {224'd0, found_nonce}, {224'd0, sb.pop_front()});
      end
    end
    if (done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
    int k;
    nonce_start   = s;
    nonce_end     = e;
    work_target   = tgt;
    work_midstate = {8{s ^ 32'hA5A5_0F0F}};
    work_tail     = {32'hDEAD_BEEF, 32'h1234_5678, ~s};
    work_valid    = 1'b1;
    k = 0;
    while (work_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (work_ready !== 1'b1) check("ready_timeout", {255'd0, work_ready}, 256'd1);
    tick();
    work_valid = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, output int c);
    c = 0;
    while (done !== 1'b1 && c < max_cyc) begin
      tick();
      c++;
    end
    if (done !== 1'b1) check("done_timeout", {255'd0, done}, 256'd1);
  endtask

  initial begin
    reset = 1'b1; work_valid = 1'b0; abort = 1'b0; found_ready = 1'b1;
    work_midstate = '0; work_tail = '0; work_target = '0; nonce_start = '0; nonce_end = '0;
    tick(); tick();
    check("rst_work_ready", {255'd0, work_ready}, 256'd0);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_data1", data1[255:0], 256'd0);
    check("rst_hash0", hash0, 256'd0);
    reset = 1'b0;
    tick();
    check("idle_work_ready", {255'd0, work_ready}, 256'd1);

    // all-ones target, 10..13, consumer always ready
    sb.push_back(32'd10); sb.push_back(32'd11); sb.push_back(32'd12); sb.push_back(32'd13);
    done0 = n_done;
    start_job(32'd10, 32'd13, '1);
    check("first_nonce", {224'd0, data1[127:96]}, 256'd10);
    check("tail", {160'd0, data1[95:0]}, {160'd0, work_tail});
    check("pad_zero", {128'd0, data1[511:384]}, 256'd0);
    check("hash0", hash0, work_midstate);
    check("scan_busy", {255'd0, busy}, 256'd1);
    check("scan_not_ready", {255'd0, work_ready}, 256'd0);
    run_until_done(30, cyc);
    check("done_latency", cyc, 9);
    tick(); tick();
    check("done_pulses", n_done - done0, 1);
    check("sb_empty_t1", sb.size(), 0);
    check("idle_busy", {255'd0, busy}, 256'd0);

    // zero target: only 0x1234 hits
    sb.push_back(32'h1234);
    start_job(32'h1230, 32'h1237, '0);
    run_until_done(40, cyc);
    tick();
    check("sb_empty_t2", sb.size(), 0);
    check("no_overflow", {255'd0, found_overflow}, 256'd0);

    // wrap through FFFFFFFF
    sb.push_back(32'hFFFF_FFFE); sb.push_back(32'hFFFF_FFFF); sb.push_back(32'h0); sb.push_back(32'h1);
    start_job(32'hFFFF_FFFE, 32'h0000_0001, '1);
    check("wrap_n0", {224'd0, data1[127:96]}, {224'd0, 32'hFFFF_FFFE});
    tick();
    check("wrap_n1", {224'd0, data1[127:96]}, {224'd0, 32'hFFFF_FFFF});
    tick();
    check("wrap_n2", {224'd0, data1[127:96]}, 256'd0);
    tick();
    check("wrap_n3", {224'd0, data1[127:96]}, 256'd1);
    run_until_done(30, cyc);
    tick();
    check("sb_empty_t3", sb.size(), 0);

    // consumer stalled: first hit held, later hits dropped
    found_ready = 1'b0;
    start_job(32'd5, 32'd7, '1);
    run_until_done(30, cyc);
    check("held_valid", {255'd0, found_valid}, 256'd1);
    check("held_nonce", {224'd0, found_nonce}, 256'd5);
    check("overflow_set", {255'd0, found_overflow}, 256'd1);
`ifdef NONCE_SCANNER_HIT_COUNT_EN
    check("hit_count", {224'd0, hit_count}, 256'd3);
`endif
    sb.push_back(32'd5);
    found_ready = 1'b1;
    tick(); tick(); tick();
    check("drained_valid", {255'd0, found_valid}, 256'd0);
    check("overflow_sticky", {255'd0, found_overflow}, 256'd1);
    check("sb_empty_t4", sb.size(), 0);

    // abort two cycles into a 100-nonce job, then immediate single-nonce job
    done0 = n_done;
    start_job(32'd100, 32'd199, '1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_ready", {255'd0, work_ready}, 256'd1);
    check("abort_idle_busy", {255'd0, busy}, 256'd0);
    sb.push_back(32'd20);
    start_job(32'd20, 32'd20, '1);
    check("reaccept_busy", {255'd0, busy}, 256'd1);
    check("reaccept_nonce", {224'd0, data1[127:96]}, 256'd20);
    tick();
    check("single_issue_drain", {224'd0, data1[127:96]}, 256'd21);
    run_until_done(30, cyc);
    tick(); tick();
    check("abort_done_pulses", n_done - done0, 1);
    check("sb_empty_t5", sb.size(), 0);

    // reset while draining with a held result
    found_ready = 1'b0;
    start_job(32'd40, 32'd43, '1);
    cyc = 0;
    while (found_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("pre_rst_valid", {255'd0, found_valid}, 256'd1);
    check("pre_rst_busy", {255'd0, busy}, 256'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", {255'd0, work_ready}, 256'd0);
    check("mid_rst_valid", {255'd0, found_valid}, 256'd0);
    check("mid_rst_nonce", {224'd0, found_nonce}, 256'd0);
    check("mid_rst_overflow", {255'd0, found_overflow}, 256'd0);
    check("mid_rst_busy", {255'd0, busy}, 256'd0);
    check("mid_rst_done", {255'd0, done}, 256'd0);
    check("mid_rst_hash0", hash0, 256'd0);
    check("mid_rst_data1", data1[255:0], 256'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {255'd0, work_ready}, 256'd1);
    found_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("sb_empty_t6", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
